// File: rtl/bcpu_ibus_responder.sv
// BCPU16 IBUS responder: four masked-write output ports, four
// double-synchronized input ports, and a registered one-cycle response
// for IN / OUT / WAITE / WAITNE with a per-thread bounded wait retry.
module bcpu_ibus_responder #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned BUS_ADDR_WIDTH  = 3,
  parameter int unsigned BUS_OP_WIDTH    = 2,
  parameter int unsigned THREAD_ID_WIDTH = 2,
  parameter int unsigned WAIT_TIMEOUT    = 0
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       REQ_VALID,
  input  logic [BUS_OP_WIDTH-1:0]    REQ_OP,
  input  logic [BUS_ADDR_WIDTH-1:0]  REQ_ADDR,
  input  logic [THREAD_ID_WIDTH-1:0] REQ_THREAD,
  input  logic [DATA_WIDTH-1:0]      REQ_A_VALUE,
  input  logic [DATA_WIDTH-1:0]      REQ_MASK,
  output logic                       RESP_VALID,
  output logic [THREAD_ID_WIDTH-1:0] RESP_THREAD,
  output logic [DATA_WIDTH-1:0]      RESP_DATA,
  output logic                       RESP_WREN,
  output logic                       RESP_Z,
  output logic                       RESP_RETRY,
  output logic                       RESP_TIMEOUT,
  output logic [4*DATA_WIDTH-1:0]    PORT_OUT,
  input  logic [4*DATA_WIDTH-1:0]    PORT_IN
);

  localparam int unsigned NUM_PORTS   = 4;
  localparam int unsigned NUM_THREADS = 1 << THREAD_ID_WIDTH;
  localparam int unsigned CNT_W       = 16;
  // Count value at which the next failed wait is force-released.
  localparam logic [CNT_W-1:0] CNT_LAST =
    (WAIT_TIMEOUT == 0) ? '0 : CNT_W'(WAIT_TIMEOUT - 1);

  typedef enum logic [BUS_OP_WIDTH-1:0] {
    OP_READ   = BUS_OP_WIDTH'(0),
    OP_WRITE  = BUS_OP_WIDTH'(1),
    OP_WAITE  = BUS_OP_WIDTH'(2),
    OP_WAITNE = BUS_OP_WIDTH'(3)
  } op_e;

  logic [DATA_WIDTH-1:0] outreg_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0] outreg_d [NUM_PORTS];
  logic [DATA_WIDTH-1:0] sync1_q  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] sync2_q  [NUM_PORTS];
  logic [CNT_W-1:0]      cnt_q    [NUM_THREADS];
  logic [CNT_W-1:0]      cnt_d    [NUM_THREADS];

  logic                       resp_valid_q,   resp_valid_d;
  logic [THREAD_ID_WIDTH-1:0] resp_thread_q,  resp_thread_d;
  logic [DATA_WIDTH-1:0]      resp_data_q,    resp_data_d;
  logic                       resp_wren_q,    resp_wren_d;
  logic                       resp_z_q,       resp_z_d;
  logic                       resp_retry_q,   resp_retry_d;
  logic                       resp_timeout_q, resp_timeout_d;

  op_e                   req_op;
  logic [1:0]            port_sel;
  logic                  in_bank;
  logic [DATA_WIDTH-1:0] addr_val;
  logic [DATA_WIDTH-1:0] masked_val;
  logic                  wait_met;
  logic                  wait_fail;
  logic [CNT_W-1:0]      cnt_cur;
  logic                  timeout_hit;

  assign req_op   = op_e'(REQ_OP);
  assign port_sel = REQ_ADDR[1:0];
  assign in_bank  = REQ_ADDR[2];

  // Addressed value and wait condition, from state held before this edge
  always_comb begin
    addr_val    = in_bank ? sync2_q[port_sel] : outreg_q[port_sel];
    masked_val  = addr_val & REQ_MASK;
    wait_met    = (((addr_val ^ REQ_A_VALUE) & REQ_MASK) == '0);
    wait_fail   = 1'b0;
    case (req_op)
      OP_WAITE:  wait_fail = !wait_met;
      OP_WAITNE: wait_fail = wait_met;
      default:   wait_fail = 1'b0;
    endcase
    cnt_cur     = cnt_q[REQ_THREAD];
    timeout_hit = (WAIT_TIMEOUT != 0) && wait_fail && (cnt_cur == CNT_LAST);
  end

  // Next-state for output registers, retry counters and the response
  always_comb begin
    outreg_d       = outreg_q;
    cnt_d          = cnt_q;
    resp_valid_d   = 1'b0;
    resp_thread_d  = '0;
    resp_data_d    = '0;
    resp_wren_d    = 1'b0;
    resp_z_d       = 1'b0;
    resp_retry_d   = 1'b0;
    resp_timeout_d = 1'b0;
    if (REQ_VALID) begin
      resp_valid_d  = 1'b1;
      resp_thread_d = REQ_THREAD;
      case (req_op)
        OP_READ: begin
          resp_data_d         = masked_val;
          resp_wren_d         = 1'b1;
          resp_z_d            = (masked_val == '0);
          cnt_d[REQ_THREAD]   = '0;
        end
        OP_WRITE: begin
          if (!in_bank) begin
            outreg_d[port_sel] = (outreg_q[port_sel] & ~REQ_MASK) |
                                 (REQ_A_VALUE & REQ_MASK);
          end
          cnt_d[REQ_THREAD] = '0;
        end
        default: begin
          if (!wait_fail) begin
            cnt_d[REQ_THREAD] = '0;
          end else if (timeout_hit) begin
            resp_timeout_d    = 1'b1;
            cnt_d[REQ_THREAD] = '0;
          end else begin
            resp_retry_d = 1'b1;
            if (cnt_cur != '1) begin
              cnt_d[REQ_THREAD] = cnt_cur + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State registers, input synchronizers and registered response
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        outreg_q[k] <= '0;
        sync1_q[k]  <= '0;
        sync2_q[k]  <= '0;
      end
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        cnt_q[t] <= '0;
      end
      resp_valid_q   <= 1'b0;
      resp_thread_q  <= '0;
      resp_data_q    <= '0;
      resp_wren_q    <= 1'b0;
      resp_z_q       <= 1'b0;
      resp_retry_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        outreg_q[k] <= outreg_d[k];
        sync1_q[k]  <= PORT_IN[k*DATA_WIDTH +: DATA_WIDTH];
        sync2_q[k]  <= sync1_q[k];
      end
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        cnt_q[t] <= cnt_d[t];
      end
      resp_valid_q   <= resp_valid_d;
      resp_thread_q  <= resp_thread_d;
      resp_data_q    <= resp_data_d;
      resp_wren_q    <= resp_wren_d;
      resp_z_q       <= resp_z_d;
      resp_retry_q   <= resp_retry_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

  // Output ports come straight from the output registers
  always_comb begin
    PORT_OUT = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      PORT_OUT[k*DATA_WIDTH +: DATA_WIDTH] = outreg_q[k];
    end
  end

  assign RESP_VALID   = resp_valid_q;
  assign RESP_THREAD  = resp_thread_q;
  assign RESP_DATA    = resp_data_q;
  assign RESP_WREN    = resp_wren_q;
  assign RESP_Z       = resp_z_q;
  assign RESP_RETRY   = resp_retry_q;
  assign RESP_TIMEOUT = resp_timeout_q;

endmodule

// File: doc/bcpu_ibus_responder.md
# bcpu_ibus_responder

Responder end of the BCPU16 IBUS protocol. It services the IN, OUT, WAITE and WAITNE requests that the execute stage issues after instruction decode. It holds four masked-write output port registers and four double-synchronized input ports, and returns a registered one-cycle response that carries data, the Z flag, a write-enable for the destination register and a retry indication for unmet waits. A per-thread retry counter bounds how long any barrel thread can spin on a WAIT instruction.

## Interface
- DATA_WIDTH, 16, port/register/data width
- BUS_ADDR_WIDTH, 3, IBUS address width; bit 2 selects input (1) or output (0) bank
- BUS_OP_WIDTH, 2, bus opcode width: 00 READ(IN), 01 WRITE(OUT), 10 WAITE, 11 WAITNE
- THREAD_ID_WIDTH, 2, barrel thread id width (4 threads)
- WAIT_TIMEOUT, 0, consecutive unmet waits before forced release; 0 disables the timeout

Ports:
- Clocking: one clock; reset is synchronous and active-low.
- CLK  in  1  clock; all state updates on rising edge
- RESET_N  in  1  synchronous active-low reset
- REQ_VALID  in  1  request present this cycle (BUS_RD_EN | BUS_WR_EN)
- REQ_OP  in  BUS_OP_WIDTH  bus opcode
- REQ_ADDR  in  BUS_ADDR_WIDTH  bus address i3
- REQ_THREAD  in  THREAD_ID_WIDTH  issuing thread
- REQ_A_VALUE  in  DATA_WIDTH  Ra value (write data / compare value)
- REQ_MASK  in  DATA_WIDTH  Rb mask (B value)
- RESP_VALID  out  1  response valid
- RESP_THREAD  out  THREAD_ID_WIDTH  thread of response
- RESP_DATA  out  DATA_WIDTH  IN result (value & mask)
- RESP_WREN  out  1  write RESP_DATA to Rd (IN only)
- RESP_Z  out  1  Z flag for IN
- RESP_RETRY  out  1  wait not satisfied; thread re-executes the instruction
- RESP_TIMEOUT  out  1  wait released by timeout
- PORT_OUT  out  4*DATA_WIDTH  output registers, port k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- PORT_IN  in  4*DATA_WIDTH  asynchronous input ports, same packing

## Operation
- Addressed value V: for addr 0-3, V = OUTREG[addr[1:0]]; for addr 4-7, V = SYNC2[addr[1:0]].
- READ: RESP_DATA = V & MASK; RESP_WREN = 1; RESP_Z = ((V & MASK) == 0).
- WRITE, addr 0-3: OUTREG <= (OUTREG & ~MASK) | (A & MASK). WRITE to addr 4-7 changes no state. Either way the response has RESP_WREN = 0 and RESP_RETRY = 0.
- met = (((V ^ A) & MASK) == 0). WAITE fails when !met; WAITNE fails when met.
- Retry counter CNT[t], 16 bits, one per thread:
  - Any non-wait request from t, or a satisfied wait: CNT[t] <= 0.
  - Failed wait with WAIT_TIMEOUT != 0 and CNT[t] == WAIT_TIMEOUT-1: RESP_TIMEOUT = 1, RESP_RETRY = 0, CNT[t] <= 0.
  - Otherwise failed wait: RESP_RETRY = 1, CNT[t] <= CNT[t] + 1, saturating at 0xFFFF.
- When RESP_VALID = 0, every RESP_* output is 0.
- PORT_OUT is driven directly from OUTREG, with no extra stage.

## Timing
- Reset (RESET_N = 0 at an edge): OUTREG, SYNC1, SYNC2, CNT and all RESP_* are cleared to 0, so PORT_OUT = 0. A request presented in a reset cycle is dropped; RESP_VALID = 0 in the following cycle.
- Latency: a request sampled at edge N produces its response registered at edge N, valid during cycle N+1. Throughput is one request per cycle with no backpressure.
- V is read from the state held before edge N. An OUT at edge N is visible to a request at edge N+1 and appears on PORT_OUT after edge N.
- Input sync: a PORT_IN value stable before edge E enters SYNC1 at E and SYNC2 at E+1. The first request that observes it is the one sampled at edge E+2.
- Back-to-back OUTs to the same port chain correctly: the second merges into the result of the first.
- Each thread's CNT is independent; interleaved threads never disturb each other's count.

## Test plan
- Reset: hold RESET_N = 0 for 2 cycles while driving REQ_VALID = 1 -> PORT_OUT = 0, RESP_VALID = 0 during reset and in the cycle after release.
- Masked write then read:
  - OUT addr1 A = 0xABCD MASK = 0x00FF -> PORT_OUT[1] = 0x00CD.
  - Then OUT A = 0x1200 MASK = 0xFF00 -> 0x12CD.
  - Then IN addr1 MASK = 0x0F0F -> RESP_DATA = 0x020D, RESP_WREN = 1, RESP_Z = 0.
  - IN addr1 MASK = 0 -> RESP_Z = 1.
- Sync latency: set PORT_IN[2] = 0x5555 just before edge E; IN addr6 MASK = 0xFFFF each cycle -> RESP_DATA = 0 for requests at E and E+1, 0x5555 for the request at E+2.
- WAITE: PORT_IN[0] = 0, WAITE addr4 A = 1 MASK = 1 issued repeatedly -> RESP_RETRY = 1. Set PORT_IN[0] = 1 -> RESP_RETRY = 0 two requests later, then CNT cleared.
- Timeout, WAIT_TIMEOUT = 3, thread 2: WAITNE on an equal value three times -> RETRY, RETRY, then TIMEOUT = 1 with RETRY = 0. A thread 1 wait interleaved between them is unaffected.
- Write to input address: OUT addr5 A = 0xFFFF MASK = 0xFFFF -> no PORT_OUT change; next IN addr5 returns the synchronized PORT_IN[1].
